// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment display path.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = lit).
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and light only the middle bar as an error marker.
module seg7_decoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    import seg7_pkg::*;

    // Look up the segment pattern for one BCD digit.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver.
// Each rising edge of scan_in advances to the next digit, with an optional
// dark gap between digits to suppress ghosting. All outputs are registered
// from next-state values so they switch on the same edge as the scan FSM.
module seg7_scan_mux #(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scan_in,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic                        blank_lz,
    output logic [N_DIGITS-1:0]         an_n,
    output logic [6:0]                  seg_n,
    output logic                        dp_n,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx
);
    import seg7_pkg::*;

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    BLANK_LOAD    = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]    LAST_IDX      = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIGIT0_ONEHOT = N_DIGITS'(1);

    scan_state_t           state_q, state_d;
    logic [CNT_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic                  scan_q, scan_d;
    logic [4*N_DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;

    logic                  rise;
    logic [3:0]            dig_nib [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_blank;
    logic [6:0]            dec_seg_n;

    // Split the next shadow value into digits and work out which digits are
    // leading zeros. Digit 0 always shows so a value of zero still reads "0".
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign dig_nib[gi] = sh_dig_d[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = blank_lz & ~(|sh_dig_d[4*N_DIGITS-1:4*gi]);
        end
    end

    seg7_decoder u_decoder (
        .bcd   (dig_nib[digit_idx_d]),
        .seg_n (dec_seg_n)
    );

    // Scan edge detection, shadow capture and BLANK/SHOW sequencing.
    always_comb begin
        scan_d      = scan_in;
        rise        = scan_in & ~scan_q;
        sh_dig_d    = load ? digits_in : sh_dig_q;
        sh_dp_d     = load ? dp_in : sh_dp_q;
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        digit_idx_d = digit_idx_q;
        case (state_q)
            SHOW: begin
                if (rise) begin
                    digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_d     = BLANK;
                        blank_cnt_d = BLANK_LOAD;
                    end
                end
            end
            BLANK: begin
                // A rise here is dropped on purpose: queuing it would skip a digit.
                if (blank_cnt_q == '0) begin
                    state_d = SHOW;
                end else begin
                    blank_cnt_d = blank_cnt_q - 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Output drive for the coming cycle, based on next state and next shadow.
    always_comb begin
        an_n_d  = '1;
        seg_n_d = SEG_OFF;
        dp_n_d  = 1'b1;
        if (state_d == SHOW && !lz_blank[digit_idx_d]) begin
            an_n_d  = ~(DIGIT0_ONEHOT << digit_idx_d);
            seg_n_d = dec_seg_n;
            dp_n_d  = ~sh_dp_d[digit_idx_d];
        end
    end

    // State and output registers; reset darkens the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            blank_cnt_q <= '0;
            digit_idx_q <= '0;
            scan_q      <= 1'b1;
            sh_dig_q    <= '0;
            sh_dp_q     <= '0;
            an_n_q      <= '1;
            seg_n_q     <= SEG_OFF;
            dp_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            digit_idx_q <= digit_idx_d;
            scan_q      <= scan_d;
            sh_dig_q    <= sh_dig_d;
            sh_dp_q     <= sh_dp_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign an_n      = an_n_q;
    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (8-cycle gap and no gap) share the
// same stimulus and are compared every cycle against a timing model.
module tb_seg7_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, scan_in, load, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an_n_a, an_n_b;
    logic [6:0]  seg_n_a, seg_n_b;
    logic        dp_n_a, dp_n_b;
    logic [1:0]  idx_a, idx_b;

    seg7_scan_mux #(.N_DIGITS(4), .BLANK_CYCLES(8)) u_dut_b8 (
        .clk(clk), .rst_n(rst_n), .scan_in(scan_in), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .an_n(an_n_a), .seg_n(seg_n_a), .dp_n(dp_n_a), .digit_idx(idx_a)
    );

    seg7_scan_mux #(.N_DIGITS(4), .BLANK_CYCLES(0)) u_dut_b0 (
        .clk(clk), .rst_n(rst_n), .scan_in(scan_in), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .an_n(an_n_b), .seg_n(seg_n_b), .dp_n(dp_n_b), .digit_idx(idx_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (index 0: 8-cycle gap, index 1: no gap).
    bit          m_prev;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    bit          m_show [2];
    int          m_gap  [2];
    int          m_idx  [2];
    logic [3:0]  e_an   [2];
    logic [6:0]  e_seg  [2];
    logic        e_dp   [2];

    // Directed-phase observation of the 8-cycle instance.
    bit         rec_on = 1'b0;
    logic [3:0] an_seq[$];
    int         dark_runs[$];
    int         dark_len;
    logic [3:0] last_an;
    int         b_dark;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Segment pattern from the list of lit segments of each numeral.
    function automatic logic [6:0] ref_seg(input int v);
        string      lit;
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            0: lit = "abcdef";
            1: lit = "bc";
            2: lit = "abdeg";
            3: lit = "abcdg";
            4: lit = "bcfg";
            5: lit = "acdfg";
            6: lit = "acdefg";
            7: lit = "abc";
            8: lit = "abcdefg";
            9: lit = "abcdfg";
            default: lit = "g";
        endcase
        for (int i = 0; i < lit.len(); i++) begin
            int k;
            k = int'(lit.getc(i)) - 97;
            s[k] = 1'b0;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_prev = 1'b1;
        m_dig  = '0;
        m_dp   = '0;
        for (int m = 0; m < 2; m++) begin
            m_show[m] = 1'b0;
            m_gap[m]  = 1;
            m_idx[m]  = 0;
            e_an[m]   = 4'hF;
            e_seg[m]  = 7'h7F;
            e_dp[m]   = 1'b1;
        end
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_step();
        bit rise;
        rise   = scan_in && !m_prev;
        m_prev = scan_in;
        if (load) begin
            m_dig = digits_in;
            m_dp  = dp_in;
        end
        for (int m = 0; m < 2; m++) begin
            int  gap_len;
            bit  lz;
            gap_len = (m == 0) ? 8 : 0;
            if (m_show[m]) begin
                if (rise) begin
                    m_idx[m] = (m_idx[m] + 1) % 4;
                    if (gap_len > 0) begin
                        m_show[m] = 1'b0;
                        m_gap[m]  = gap_len;
                    end
                end
            end else begin
                m_gap[m]--;
                if (m_gap[m] == 0) m_show[m] = 1'b1;
            end
            lz = blank_lz && (m_idx[m] > 0) && ((m_dig >> (4 * m_idx[m])) == 0);
            if (m_show[m] && !lz) begin
                e_an[m]  = ~(4'b0001 << m_idx[m]);
                e_seg[m] = ref_seg(int'((m_dig >> (4 * m_idx[m])) & 16'hF));
                e_dp[m]  = ~m_dp[m_idx[m]];
            end else begin
                e_an[m]  = 4'hF;
                e_seg[m] = 7'h7F;
                e_dp[m]  = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("an_n/gap8",  an_n_a,  e_an[0]);
        check_eq("seg_n/gap8", seg_n_a, e_seg[0]);
        check_eq("dp_n/gap8",  dp_n_a,  e_dp[0]);
        check_eq("idx/gap8",   idx_a,   m_idx[0]);
        check_eq("an_n/gap0",  an_n_b,  e_an[1]);
        check_eq("seg_n/gap0", seg_n_b, e_seg[1]);
        check_eq("dp_n/gap0",  dp_n_b,  e_dp[1]);
        check_eq("idx/gap0",   idx_b,   m_idx[1]);
    endtask

    task automatic record();
        if (an_n_a != 4'hF) begin
            if (last_an == 4'hF) dark_runs.push_back(dark_len);
            if (an_n_a != last_an) an_seq.push_back(an_n_a);
        end else begin
            if (last_an != 4'hF) dark_len = 0;
            dark_len++;
        end
        last_an = an_n_a;
        if (an_n_b == 4'hF) b_dark++;
    endtask

    task automatic tick(input logic s, input logic ld, input logic [15:0] d,
                        input logic [3:0] p, input logic bz);
        scan_in   = s;
        load      = ld;
        digits_in = d;
        dp_in     = p;
        blank_lz  = bz;
        if (ld) $display("load digits=%h dp=%b blank_lz=%0d at %0t", d, p, bz, $time);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (rec_on) record();
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted at %0t", $time);
        check_eq("async an_n/gap8",  an_n_a,  4'hF);
        check_eq("async seg_n/gap8", seg_n_a, 7'h7F);
        check_eq("async dp_n/gap8",  dp_n_a,  1'b1);
        check_eq("async idx/gap8",   idx_a,   0);
        check_eq("async an_n/gap0",  an_n_b,  4'hF);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    localparam logic [3:0] EXP_SEQ [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        logic        s;
        bit          saw_hi, saw_d1, saw_dash, did_reset;
        int          hold;
        logic        bz;

        rst_n = 1'b0; scan_in = 1'b1; load = 1'b0;
        digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        #1;
        compare_all();

        // First edge after release: digit 0 appears, scan_in high gave no edge.
        tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        check_eq("first an_n", an_n_a, 4'b1110);

        // Load 1,2,3,4 (digit 0 = 4) mid-digit and scan five times.
        tick(1'b1, 1'b1, 16'h1234, 4'b0001, 1'b0);
        check_eq("digit0 seg_n", seg_n_a, 7'b0011001);
        check_eq("digit0 dp_n", dp_n_a, 1'b0);
        an_seq.delete(); dark_runs.delete();
        an_seq.push_back(an_n_a);
        last_an = an_n_a; dark_len = 0; b_dark = 0;
        rec_on = 1'b1;
        for (int r = 0; r < 5; r++) begin
            repeat (2)  tick(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
            repeat (12) tick(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        end
        rec_on = 1'b0;
        check_eq("anode count", an_seq.size(), 6);
        for (int i = 0; i < 5 && i < an_seq.size(); i++) check_eq("anode seq", an_seq[i], EXP_SEQ[i]);
        check_eq("dark run count", dark_runs.size(), 5);
        foreach (dark_runs[i]) check_eq("dark run len", dark_runs[i], 8);
        check_eq("gap0 dark cycles", b_dark, 0);

        // Leading-zero blanking with 0,0,7,0.
        saw_hi = 1'b0; saw_d1 = 1'b0;
        tick(scan_in, 1'b1, 16'h0070, 4'h0, 1'b1);
        for (int c = 0; c < 120; c++) begin
            tick(((c / 3) % 2) == 0, 1'b0, 16'h0, 4'h0, 1'b1);
            if (!an_n_a[3] || !an_n_a[2] || !an_n_b[3] || !an_n_b[2]) saw_hi = 1'b1;
            if (an_n_a == 4'b1101 && seg_n_a == 7'h78) saw_d1 = 1'b1;
        end
        check_eq("lz high digits lit", saw_hi, 1'b0);
        check_eq("lz digit1 shown", saw_d1, 1'b1);

        // Invalid code 12 in digit 1 shows a dash.
        saw_dash = 1'b0;
        tick(scan_in, 1'b1, 16'h00C0, 4'h0, 1'b0);
        for (int c = 0; c < 60; c++) begin
            tick(((c / 2) % 2) == 0, 1'b0, 16'h0, 4'h0, 1'b0);
            if (an_n_b == 4'b1101 && seg_n_b == 7'h3F) saw_dash = 1'b1;
        end
        check_eq("dash on digit1", saw_dash, 1'b1);

        // Randomized run, with one asynchronous reset while showing.
        s = scan_in; hold = 0; bz = 1'b0; did_reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic ld;
            if (hold == 0) begin
                s    = ~s;
                hold = $urandom_range(1, 12);
            end
            hold--;
            ld = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) bz = ~bz;
            tick(s, ld, rand_digits(), 4'($urandom_range(0, 15)), bz);
            if (!did_reset && c >= 1500 && m_show[0]) begin
                async_reset();
                did_reset = 1'b1;
            end
        end
        check_eq("async reset done", did_reset, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed 7-segment display driver sitting directly downstream of the clock divider. It consumes the divider's slow square wave as a scan strobe, holds a captured copy of the BCD digits from the Gray/Binary/Decimal conversion path, and drives one common-anode digit at a time. A blanking interval between digits suppresses ghosting.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits (2..8).
- `BLANK_CYCLES`, 8: `clk` cycles with all anodes off between digits; 0 disables blanking.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scan_in`  in  1  divider output, synchronous to `clk`; each rising edge advances one digit.
- `load`  in  1  single-cycle strobe; captures `digits_in` and `dp_in` into the shadow register.
- `digits_in`  in  4*N_DIGITS  BCD digits; digit i at bits [4i+3:4i], digit 0 least significant.
- `dp_in`  in  N_DIGITS  decimal point per digit, 1 = lit.
- `blank_lz`  in  1  1 = blank leading zeros.
- `an_n`  out  N_DIGITS  anode enables, active-low.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `digit_idx`  out  $clog2(N_DIGITS)  index of the current or next digit.

## Operation
- Edge detect: `scan_q` register, reset value 1; `rise = scan_in & ~scan_q`. A high `scan_in` at reset release produces no edge.
- Shadow: `sh_dig` and `sh_dp` load on `load`, reset to 0. Outputs always use the shadow, never `digits_in`.
- FSM states `BLANK` and `SHOW`; reset state is `BLANK` with `blank_cnt=0` and `digit_idx=0`.
  - `SHOW` + `rise`: `digit_idx` advances (N_DIGITS-1 wraps to 0).
    - If BLANK_CYCLES>0: go to `BLANK`, `blank_cnt=BLANK_CYCLES-1`.
    - If BLANK_CYCLES=0: stay in `SHOW`.
  - `BLANK`: decrement `blank_cnt`; at 0 go to `SHOW`. `rise` in `BLANK` is ignored and not queued.
  - The first exit from reset goes `BLANK` -> `SHOW` after one cycle, showing digit 0.
- Decode (sub-module):
  - Values 0-9 use standard patterns, e.g. 0 -> a..f lit, `seg_n=7'b1000000`; 8 -> `7'b0000000`.
  - Values 10-15 show a dash (g only, `7'b0111111`) as an error marker.
- Leading-zero blank: digit i>0 is blanked when `blank_lz=1` and `sh_dig[i]` and all higher digits are 0. Digit 0 is never blanked.
- Outputs in `SHOW`, current digit not blanked: `an_n=~(1<<digit_idx)`, `seg_n=decode(sh_dig[idx])`, `dp_n=~sh_dp[idx]`.
- Outputs otherwise (`BLANK`, or a blanked digit): `an_n` all 1, `seg_n` all 1, `dp_n=1`.

## Timing
- Reset values: `an_n` all 1, `seg_n=7'h7F`, `dp_n=1`, `digit_idx=0`.
- `an_n`, `seg_n` and `dp_n` are registers computed from next-state values, so they change on the same edge as the FSM.
- `rise` true in cycle k:
  - Anodes go off at the end of cycle k.
  - The new digit appears at the edge ending cycle k+BLANK_CYCLES.
- `load` in cycle k: the new shadow value is visible on `seg_n` and `dp_n` from edge k+1, even mid-digit.
- Simultaneous `load` and `rise`: the new digit shows the newly loaded value.
- `rst_n` low mid-operation: all registers clear immediately and asynchronously, and outputs go dark without waiting for a clock.

## Structure
- Package `seg7_pkg`: state enum `scan_state_t {BLANK, SHOW}`, segment constants `SEG_OFF=7'h7F` and `SEG_DASH=7'h3F`, and the 0-9 pattern constants.
- Sub-module `seg7_decoder`: purely combinational, 4-bit BCD in, 7-bit active-low `seg_n` out. It is shared with any other display path.

## Test plan
- Reset with `scan_in=1`, then release: no edge detected. Outputs dark for one cycle, then `an_n=4'b1110` showing digit 0.
- Load digits 1,2,3,4 (digit 0=4), `blank_lz=0`, then apply 5 scan rises:
  - Anode sequence 1110, 1101, 1011, 0111, 1110.
  - `seg_n` for digit 0 is `7'b0011001`.
  - Exactly 8 dark cycles between digits.
- Load 0,0,7,0 (digit 3=0, digit 2=0), `blank_lz=1`: `an_n` never asserts for digits 3 and 2; digits 1 (7) and 0 (0) display.
- Load value 12 in digit 1: `seg_n=7'b0111111` when digit 1 is active.
- Give `rise` during `BLANK`: ignored, no skipped digit. With BLANK_CYCLES=0: one digit per rise and no dark cycles.
- Assert `rst_n` low mid-`SHOW`: outputs go dark before the next clock edge; after release, scanning resumes at digit 0 and the shadow reads 0.
